// File: rtl/blink_led_button_ctrl.sv
// Push-button front end: synchronizes and debounces a raw button, flags long presses
// as LED override writes and turns short presses into run requests for a busy/ready stage.
module blink_led_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    input  logic       run_busy,
    output logic       run_req,
    output logic       led_we,
    output logic       led_in,
    output logic       btn_level,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {IDLE, WAIT_READY, REQ} state_t;

    localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
    localparam logic [31:0] LONG_MAX  = 32'(LONG_CYCLES);

    logic        sync1_reg;
    logic        sync_reg;
    logic [23:0] db_cnt_reg;
    logic        btn_level_reg;
    logic        level_prev_reg;
    logic [31:0] hold_cnt_reg;
    logic        led_toggle_reg;
    logic        led_we_reg;
    logic        run_req_reg;
    logic [7:0]  press_count_reg;
    state_t      state_reg;
    state_t      state_next;
    logic        count_inc;
    logic        short_press;
    logic        long_hit;

    // The hold counter still carries the pre-release value in the cycle after the fall.
    assign short_press = level_prev_reg && !btn_level_reg && (hold_cnt_reg < LONG_MAX);
    assign long_hit    = btn_level_reg && (hold_cnt_reg == LONG_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg      <= 1'b0;
            sync_reg       <= 1'b0;
            db_cnt_reg     <= '0;
            btn_level_reg  <= 1'b0;
            level_prev_reg <= 1'b0;
        end else begin
            sync1_reg      <= btn_in;
            sync_reg       <= sync1_reg;
            level_prev_reg <= btn_level_reg;
            if (sync_reg == btn_level_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                btn_level_reg <= sync_reg;
                db_cnt_reg    <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_reg   <= '0;
            led_toggle_reg <= 1'b0;
            led_we_reg     <= 1'b0;
        end else begin
            led_we_reg <= long_hit;
            if (long_hit) begin
                led_toggle_reg <= !led_toggle_reg;
            end
            if (!btn_level_reg) begin
                hold_cnt_reg <= '0;
            end else if (hold_cnt_reg != LONG_MAX) begin
                hold_cnt_reg <= hold_cnt_reg + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        count_inc  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (short_press) begin
                    count_inc  = 1'b1;
                    state_next = run_busy ? WAIT_READY : REQ;
                end
            end
            WAIT_READY: begin
                if (!run_busy) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (run_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            run_req_reg     <= 1'b0;
            press_count_reg <= '0;
        end else begin
            state_reg   <= state_next;
            run_req_reg <= (state_next == REQ);
            if (count_inc) begin
                press_count_reg <= press_count_reg + 8'd1;
            end
        end
    end

    assign run_req     = run_req_reg;
    assign led_we      = led_we_reg;
    assign led_in      = led_toggle_reg;
    assign btn_level   = btn_level_reg;
    assign press_count = press_count_reg;

endmodule

// File: tb/tb_blink_led_button_ctrl.sv
// Directed bench for blink_led_button_ctrl with short debounce/long-press windows.
module tb_blink_led_button_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_in;
    logic       run_busy;
    logic       run_req;
    logic       led_we;
    logic       led_in;
    logic       btn_level;
    logic [7:0] press_count;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int led_we_cnt    = 0;
    int rise_cnt      = 0;
    int rise_base;

    blink_led_button_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .run_busy   (run_busy),
        .run_req    (run_req),
        .led_we     (led_we),
        .led_in     (led_in),
        .btn_level  (btn_level),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (led_we) led_we_cnt++;
    always @(posedge btn_level) rise_cnt++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the button for hi cycles, then wait until the release has reached the FSM.
    task automatic press(input int hi);
        btn_in = 1'b1;
        step(hi);
        btn_in = 1'b0;
        step(7);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        btn_in   = 1'b0;
        run_busy = 1'b0;
        step(2);
        check_val("rst_run_req", 32'(run_req), 32'd0);
        check_val("rst_led_we", 32'(led_we), 32'd0);
        check_val("rst_led_in", 32'(led_in), 32'd0);
        check_val("rst_btn_level", 32'(btn_level), 32'd0);
        check_val("rst_press_count", 32'(press_count), 32'd0);
        reset = 1'b0;
        step(2);

        // Glitch shorter than the debounce window
        btn_in = 1'b1;
        step(2);
        btn_in = 1'b0;
        step(20);
        check_val("glitch_level", 32'(btn_level), 32'd0);
        check_val("glitch_run_req", 32'(run_req), 32'd0);
        check_val("glitch_count", 32'(press_count), 32'd0);

        // Short press, downstream ready
        btn_in = 1'b1;
        step(5);
        check_val("rise_lat5", 32'(btn_level), 32'd0);
        step(1);
        check_val("rise_lat6", 32'(btn_level), 32'd1);
        step(4);
        btn_in = 1'b0;
        step(5);
        check_val("fall_lat5", 32'(btn_level), 32'd1);
        step(1);
        check_val("fall_lat6", 32'(btn_level), 32'd0);
        check_val("req_not_yet", 32'(run_req), 32'd0);
        step(1);
        check_val("req_rise", 32'(run_req), 32'd1);
        check_val("count_1", 32'(press_count), 32'd1);
        step(1);
        check_val("req_held", 32'(run_req), 32'd1);
        run_busy = 1'b1;
        step(1);
        check_val("req_accepted", 32'(run_req), 32'd0);
        run_busy = 1'b0;
        step(2);
        check_val("req_stays_low", 32'(run_req), 32'd0);
        check_val("short_no_led", 32'(led_in), 32'd0);

        // Short press while busy -> WAIT_READY
        run_busy = 1'b1;
        press(10);
        check_val("wait_no_req", 32'(run_req), 32'd0);
        check_val("count_2", 32'(press_count), 32'd2);
        step(3);
        check_val("wait_still", 32'(run_req), 32'd0);
        run_busy = 1'b0;
        step(1);
        check_val("wait_to_req", 32'(run_req), 32'd1);
        press(10);
        check_val("drop_in_req_count", 32'(press_count), 32'd2);
        check_val("drop_in_req_req", 32'(run_req), 32'd1);
        run_busy = 1'b1;
        step(1);
        check_val("drop_accept", 32'(run_req), 32'd0);
        run_busy = 1'b0;
        step(2);

        // Long press toggles LED once, release issues nothing
        btn_in = 1'b1;
        step(6);
        check_val("long_level", 32'(btn_level), 32'd1);
        step(19);
        check_val("long_we_early", 32'(led_we), 32'd0);
        step(1);
        check_val("long_we", 32'(led_we), 32'd1);
        check_val("long_led_in1", 32'(led_in), 32'd1);
        step(1);
        check_val("long_we_one", 32'(led_we), 32'd0);
        step(3);
        btn_in = 1'b0;
        step(7);
        check_val("long_no_req", 32'(run_req), 32'd0);
        check_val("long_no_count", 32'(press_count), 32'd2);
        btn_in = 1'b1;
        step(26);
        check_val("long2_we", 32'(led_we), 32'd1);
        check_val("long2_led_in0", 32'(led_in), 32'd0);
        step(4);
        btn_in = 1'b0;
        step(7);
        check_val("long2_no_req", 32'(run_req), 32'd0);
        check_val("led_we_pulses", 32'(led_we_cnt), 32'd2);

        // Chattering then steady high
        rise_base = rise_cnt;
        for (int i = 0; i < 10; i++) begin
            btn_in = (i % 2 == 0);
            step(2);
        end
        btn_in = 1'b1;
        step(10);
        check_val("chatter_level", 32'(btn_level), 32'd1);
        check_val("chatter_rises", 32'(rise_cnt - rise_base), 32'd1);
        btn_in = 1'b0;
        step(7);
        check_val("chatter_req", 32'(run_req), 32'd1);
        check_val("count_3", 32'(press_count), 32'd3);
        run_busy = 1'b1;
        step(1);
        run_busy = 1'b0;
        step(2);

        // Asynchronous reset mid-request
        press(10);
        check_val("pre_reset_req", 32'(run_req), 32'd1);
        reset = 1'b1;
        #1;
        check_val("async_req_drop", 32'(run_req), 32'd0);
        check_val("async_count_clr", 32'(press_count), 32'd0);
        step(1);
        reset = 1'b0;
        step(5);
        check_val("no_reissue", 32'(run_req), 32'd0);

        // Wrap of press_count
        for (int i = 0; i < 256; i++) begin
            press(10);
            run_busy = 1'b1;
            step(1);
            run_busy = 1'b0;
            step(1);
            if (i == 254) check_val("count_255", 32'(press_count), 32'd255);
        end
        check_val("count_wrap", 32'(press_count), 32'd0);
        check_val("wrap_req_idle", 32'(run_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
